// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family: slice width,
// sequencer state encoding and the slice-index width helper.
package cla_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width for a given slice count; never narrower than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group
// propagate/generate feeding a second lookahead level.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        c,
  output logic        p,
  output logic        g
);

  logic [15:0] bp;
  logic [15:0] bg;
  logic [15:0] bc;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  always_comb begin
    bp = a ^ b;
    bg = a & b;
    bc = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &bp[4*k +: 4];
      gg[k] = bg[4*k+3]
            | (bp[4*k+3] & bg[4*k+2])
            | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
            | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
    end

    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    // Bit carries inside each group are expanded from the group carry-in.
    for (int k = 0; k < 4; k++) begin
      bc[4*k]   = gc[k];
      bc[4*k+1] = bg[4*k] | (bp[4*k] & gc[k]);
      bc[4*k+2] = bg[4*k+1] | (bp[4*k+1] & bg[4*k])
                | (bp[4*k+1] & bp[4*k] & gc[k]);
      bc[4*k+3] = bg[4*k+2] | (bp[4*k+2] & bg[4*k+1])
                | (bp[4*k+2] & bp[4*k+1] & bg[4*k])
                | (bp[4*k+2] & bp[4*k+1] & bp[4*k] & gc[k]);
    end

    s = bp ^ bc;
    c = gc[4];
    p = &gp;
    g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
      | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract that streams 16-bit slices, LSB first,
// through a single cla16 and registers the inter-slice carry.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;

  logic [SLICE_W-1:0] cla_a;
  logic [SLICE_W-1:0] cla_b;
  logic [SLICE_W-1:0] cla_s;
  logic               cla_c;
  logic               cla_p_unused;
  logic               cla_g_unused;

  assign cla_a = a_r[SLICE_W*idx +: SLICE_W];
  assign cla_b = b_r[SLICE_W*idx +: SLICE_W];

  cla16 u_cla16 (
    .a   (cla_a),
    .b   (cla_b),
    .cin (carry_r),
    .s   (cla_s),
    .c   (cla_c),
    .p   (cla_p_unused),
    .g   (cla_g_unused)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. The producer holds its payload until then; in_ready is high
  // only in IDLE and out_valid only in DONE, where sum/cout/ovf stay frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry_r  <= sub | cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[SLICE_W*idx +: SLICE_W] <= cla_s;
          carry_r <= cla_c;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // The top slice is in flight, so cla_s[MSB] is the final sum MSB.
            cout      <= cla_c;
            ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                         (cla_s[SLICE_W-1] != a_r[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=64): vector table plus hand-written
// backpressure and mid-operation reset sequences.
module tb_cla_seq_adder;

  localparam int W   = 64;
  localparam int LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int failures;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[10];

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid; returns the number of edges waited.
  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input int id, input vec_t v);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check($sformatf("v%0d_in_ready", id), W'(in_ready), W'(1));
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    wait_out_valid(lat);
    check($sformatf("v%0d_latency", id), W'(lat), W'(LAT));
    check($sformatf("v%0d_sum", id), sum, v.exp_sum);
    check($sformatf("v%0d_cout", id), W'(cout), W'(v.exp_cout));
    check($sformatf("v%0d_ovf", id), W'(ovf), W'(v.exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("v%0d_out_valid_drop", id), W'(out_valid), W'(0));
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 64'h2222_2222_2222_2212, 1'b0, 1'b0};
    vecs[8] = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[9] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};

    #12;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(ovf), W'(0));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_op(i, vecs[i]);

    // Backpressure: result held while a new request waits.
    a = 64'd1; b = 64'd2; in_valid = 1'b1;
    tick();
    a = 64'd10; b = 64'd20;
    wait_out_valid(lat);
    check("bp_latency", W'(lat), W'(LAT));
    check("bp_sum", sum, 64'd3);
    held_sum = sum;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_hold%0d_in_ready", k), W'(in_ready), W'(0));
      check($sformatf("bp_hold%0d_out_valid", k), W'(out_valid), W'(1));
      check($sformatf("bp_hold%0d_sum", k), sum, held_sum);
      check($sformatf("bp_hold%0d_cout", k), W'(cout), W'(0));
      check($sformatf("bp_hold%0d_ovf", k), W'(ovf), W'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_in_ready", W'(in_ready), W'(1));
    check("bp_idle_out_valid", W'(out_valid), W'(0));
    tick();
    in_valid = 1'b0;
    check("bp_accept_in_ready", W'(in_ready), W'(0));
    wait_out_valid(lat);
    check("bp2_latency", W'(lat), W'(LAT));
    check("bp2_sum", sum, 64'd30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation after two RUN cycles.
    a = 64'h0000_0000_0000_FFFF; b = 64'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_sum", sum, '0);
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post_rst%0d_out_valid", k), W'(out_valid), W'(0));
    end
    run_op(100, vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
